// File: rtl/tpu_seq.sv
// tpu_seq: command sequencer in front of the tpuv1 register port.
// Loads A rows, B rows and optional C-init words from an input stream, fires
// the matmul, waits a fixed latency, then reads C back as an output stream.
//
// Handshakes: a word moves on in_* when in_valid && in_ready at a rising
// clk edge, and on out_* when out_valid && out_ready at a rising clk edge.
// A valid source holds its data stable until the transfer happens; ready may
// depend on state only, never on valid.
module tpu_seq #(
  parameter int DIM       = 8,
  parameter int BITS_C    = 16,
  parameter int ADDRW     = 16,
  parameter int DATAW     = 64,
  parameter int MM_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             load_c,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             tpu_rw,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_wdata,
  input  logic [DATAW-1:0] tpu_rdata,
  output logic [2:0]       dbg_state
);

  // Each C row spans C_WPR data words; the address map assumes two.
  localparam int C_WPR   = (DIM * BITS_C) / DATAW;
  localparam int C_WORDS = DIM * C_WPR;
  localparam int CW      = $clog2(C_WORDS) + 1;
  localparam int WW      = $clog2(MM_CYCLES + 1);

  localparam logic [CW-1:0] LAST_AB = CW'(DIM - 1);
  localparam logic [CW-1:0] LAST_C  = CW'(C_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LD_A = 3'd1,
    S_LD_B = 3'd2,
    S_LD_C = 3'd3,
    S_MM   = 3'd4,
    S_WAIT = 3'd5,
    S_RD_C = 3'd6,
    S_DONE = 3'd7
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   idx;
  logic [WW-1:0]   wait_cnt;
  logic            load_c_q;
  logic            rd_issued;
  logic            in_fire;
  logic            out_fire;
  logic            wait_end;
  logic            rd_issue;

  // C word j lives at 0x300 + 16*(j/2) + 8*(j%2).
  function automatic logic [ADDRW-1:0] c_addr(input logic [CW-1:0] j);
    return ADDRW'(16'h300) + (ADDRW'(j >> 1) << 4) + (ADDRW'(j[0]) << 3);
  endfunction

  assign in_ready  = (state == S_LD_A) || (state == S_LD_B) || (state == S_LD_C);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign wait_end  = (state == S_WAIT) && (wait_cnt == WW'(MM_CYCLES - 1));
  // Next read goes out only once the previous word has been handed off.
  assign rd_issue  = (state == S_RD_C) && !rd_issued && !out_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_LD_A;
      S_LD_A: if (in_fire && idx == LAST_AB) state_nxt = S_LD_B;
      S_LD_B: if (in_fire && idx == LAST_AB) state_nxt = load_c_q ? S_LD_C : S_MM;
      S_LD_C: if (in_fire && idx == LAST_C) state_nxt = S_MM;
      S_MM:   state_nxt = S_WAIT;
      S_WAIT: if (wait_end) state_nxt = S_RD_C;
      S_RD_C: if (out_fire && idx == LAST_C) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Word index and latency counters; both restart on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      wait_cnt <= '0;
    end else if (state_nxt != state) begin
      idx      <= '0;
      wait_cnt <= '0;
    end else begin
      if (in_fire || ((state == S_RD_C) && out_fire)) idx <= idx + CW'(1);
      if (state == S_WAIT) wait_cnt <= wait_cnt + WW'(1);
    end
  end

  // C-load option is captured only when a command is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       load_c_q <= 1'b0;
    else if (state == S_IDLE && start) load_c_q <= load_c;
  end

  // tpuv1 command bus: idle (all zero) unless a single-cycle access is due.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tpu_rw    <= 1'b0;
      tpu_addr  <= '0;
      tpu_wdata <= '0;
    end else begin
      tpu_rw    <= 1'b0;
      tpu_addr  <= '0;
      tpu_wdata <= '0;
      if (in_fire) begin
        tpu_rw    <= 1'b1;
        tpu_wdata <= in_data;
        case (state)
          S_LD_A:  tpu_addr <= ADDRW'(16'h100) + (ADDRW'(idx) << 3);
          S_LD_B:  tpu_addr <= ADDRW'(16'h200);
          default: tpu_addr <= c_addr(idx);
        endcase
      end else if (state == S_MM) begin
        tpu_addr <= ADDRW'(16'h400);
      end else if (wait_end) begin
        tpu_addr <= c_addr('0);
      end else if (rd_issue) begin
        tpu_addr <= c_addr(idx);
      end
    end
  end

  // Read-back: capture tpu_rdata the cycle after a read address, hold until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_issued <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (wait_end || rd_issue) begin
        rd_issued <= 1'b1;
      end else if (rd_issued) begin
        rd_issued <= 1'b0;
        out_valid <= 1'b1;
        out_data  <= tpu_rdata;
        out_last  <= (idx == LAST_C);
      end
      if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tpu_seq.sv
// Bench for tpu_seq: randomized commands, a small tpuv1 register model, and a
// scoreboard that checks every non-idle tpuv1 bus cycle and every output word.
module tb_tpu_seq;

  localparam int DIM       = 8;
  localparam int BITS_C    = 16;
  localparam int ADDRW     = 16;
  localparam int DATAW     = 64;
  localparam int MM_CYCLES = 32;
  localparam int NC        = 2 * DIM;
  localparam int BW        = 1 + ADDRW + DATAW;
  localparam int OW        = 1 + DATAW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             load_c = 1'b0;
  logic             in_valid = 1'b0;
  logic [DATAW-1:0] in_data = '0;
  logic             out_ready = 1'b1;
  logic             busy, done, in_ready, out_valid, out_last, tpu_rw;
  logic [DATAW-1:0] out_data, tpu_wdata, tpu_rdata;
  logic [ADDRW-1:0] tpu_addr;
  logic [2:0]       dbg_state;

  int checks = 0;
  int failures = 0;

  logic [BW-1:0] exp_q[$];      // expected tpuv1 bus cycles {rw, addr, wdata}
  logic [OW-1:0] exp_out_q[$];  // expected output words {last, data}

  tpu_seq #(
    .DIM(DIM), .BITS_C(BITS_C), .ADDRW(ADDRW), .DATAW(DATAW), .MM_CYCLES(MM_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_c(load_c),
    .busy(busy), .done(done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .tpu_rw(tpu_rw), .tpu_addr(tpu_addr), .tpu_wdata(tpu_wdata), .tpu_rdata(tpu_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- tpuv1 C register model ----------------
  logic [DATAW-1:0] c_mem [NC];
  logic [DATAW-1:0] c_init [NC];
  logic             preset = 1'b0;

  function automatic int c_index(input logic [ADDRW-1:0] a);
    int v;
    v = int'(a) - 'h300;
    if (v < 0 || v >= 8 * NC || (v % 8) != 0) return -1;
    return v / 8;
  endfunction

  always @(posedge clk) begin
    if (preset) begin
      for (int k = 0; k < NC; k++) c_mem[k] <= c_init[k];
    end else if (tpu_rw && c_index(tpu_addr) >= 0) begin
      c_mem[c_index(tpu_addr)] <= tpu_wdata;
    end
  end

  always_comb begin
    tpu_rdata = '0;
    if (!tpu_rw && c_index(tpu_addr) >= 0) tpu_rdata = c_mem[c_index(tpu_addr)];
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] mk_bus(input logic rw, input int addr, input logic [DATAW-1:0] d);
    return {rw, addr[ADDRW-1:0], d};
  endfunction

  function automatic logic [DATAW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int cyc = 0;
  int strobe_cyc = -1000;
  int last_hs_cyc = -1000;
  int done_cnt = 0;
  int op_hs = 0;
  logic             prev_wait = 1'b0;
  logic [DATAW-1:0] prev_data = '0;
  logic             prev_last = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (!rst_n) begin
        op_hs = 0;
        prev_wait = 1'b0;
      end else begin
        if (tpu_rw || tpu_addr != '0 || tpu_wdata != '0) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL bus_unexpected: got %0h expected no access", {tpu_rw, tpu_addr, tpu_wdata});
          end else begin
            check("bus", {tpu_rw, tpu_addr, tpu_wdata}, exp_q.pop_front());
          end
          if (!tpu_rw && tpu_addr == 16'h400) strobe_cyc = cyc;
          if (!tpu_rw && tpu_addr == 16'h300) check("mm_wait", cyc - strobe_cyc, MM_CYCLES);
        end
        if (out_valid && prev_wait) check("out_hold", {out_last, out_data}, {prev_last, prev_data});
        if (out_valid && out_ready) begin
          if (exp_out_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out_unexpected: got %0h expected no word", {out_last, out_data});
          end else begin
            check("out_word", {out_last, out_data}, exp_out_q.pop_front());
          end
          op_hs++;
          last_hs_cyc = cyc;
        end
        prev_wait = out_valid && !out_ready;
        prev_data = out_data;
        prev_last = out_last;
        if (done) begin
          check("done_timing", cyc - last_hs_cyc, 1);
          check("done_busy", busy, 1'b1);
          check("done_out_empty", exp_out_q.size(), 0);
          done_cnt++;
          op_hs = 0;
        end
      end
    end
  end

  // ---------------- output-side ready driver ----------------
  logic stall_en = 1'b0;
  logic rand_ready = 1'b0;
  int   stall_left = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (stall_en && op_hs == 5 && out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // ---------------- input driver tasks ----------------
  function automatic int gap_of(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 2;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic send_word(input logic [DATAW-1:0] w, input int gap);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_start(input logic lc);
    start  = 1'b1;
    load_c = lc;
    @(negedge clk);
    start  = 1'b0;
    load_c = 1'(($urandom_range(0, 1)));
  endtask

  task automatic run_op(input logic lc, input int gap_mode, input logic poke,
                        input logic stall, input logic rr);
    logic [DATAW-1:0] a [DIM];
    logic [DATAW-1:0] b [DIM];
    logic [DATAW-1:0] cw [NC];
    int d0;
    int t;
    for (int i = 0; i < DIM; i++) begin
      a[i] = rnd64();
      b[i] = rnd64();
    end
    for (int j = 0; j < NC; j++) begin
      cw[j]     = rnd64();
      c_init[j] = rnd64();
    end
    preset = 1'b1;
    @(negedge clk);
    preset = 1'b0;

    // Expected tpuv1 traffic and output stream for this command.
    for (int i = 0; i < DIM; i++) exp_q.push_back(mk_bus(1'b1, 'h100 + 8 * i, a[i]));
    for (int i = 0; i < DIM; i++) exp_q.push_back(mk_bus(1'b1, 'h200, b[i]));
    if (lc) for (int j = 0; j < NC; j++) exp_q.push_back(mk_bus(1'b1, 'h300 + 8 * j, cw[j]));
    exp_q.push_back(mk_bus(1'b0, 'h400, '0));
    for (int j = 0; j < NC; j++) begin
      exp_q.push_back(mk_bus(1'b0, 'h300 + 8 * j, '0));
      exp_out_q.push_back({(j == NC - 1), (lc ? cw[j] : c_init[j])});
    end

    stall_en   = stall;
    stall_left = 10;
    rand_ready = rr;
    d0 = done_cnt;

    pulse_start(lc);
    for (int i = 0; i < DIM; i++) send_word(a[i], gap_of(gap_mode));
    for (int i = 0; i < DIM; i++) send_word(b[i], gap_of(gap_mode));
    if (lc) for (int j = 0; j < NC; j++) send_word(cw[j], gap_of(gap_mode));

    if (poke) begin
      repeat (12) begin
        start    = 1'b1;
        load_c   = ~lc;
        in_valid = 1'b1;
        in_data  = rnd64();
        @(negedge clk);
      end
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
    end

    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", done_cnt - d0, 1);
    @(negedge clk);
    #1;
    check("idle_busy", busy, 1'b0);
    check("done_pulse_width", done, 1'b0);
    check("bus_q_drained", exp_q.size(), 0);
    check("out_q_drained", exp_out_q.size(), 0);
    exp_q.delete();
    exp_out_q.delete();
    stall_en   = 1'b0;
    rand_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_mid_ldb();
    logic [DATAW-1:0] a [DIM];
    logic [DATAW-1:0] b [3];
    for (int i = 0; i < DIM; i++) begin
      a[i] = rnd64();
      exp_q.push_back(mk_bus(1'b1, 'h100 + 8 * i, a[i]));
    end
    for (int i = 0; i < 3; i++) begin
      b[i] = rnd64();
      exp_q.push_back(mk_bus(1'b1, 'h200, b[i]));
    end
    pulse_start(1'b0);
    for (int i = 0; i < DIM; i++) send_word(a[i], 0);
    for (int i = 0; i < 3; i++) send_word(b[i], 0);
    @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = rnd64();
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_tpu_addr", tpu_addr, '0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_tpu_rw", tpu_rw, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_bus_q_drained", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    rst_n    = 1'b1;
    @(negedge clk);
    #1;
    check("post_reset_busy", busy, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_last", out_last, 1'b0);
    check("reset_tpu_bus", {tpu_rw, tpu_addr, tpu_wdata}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, 0, 1'b0, 1'b0, 1'b0);  // plain command, continuous input
    run_op(1'b1, 0, 1'b0, 1'b0, 1'b0);  // with C-init stream
    run_op(1'b0, 1, 1'b0, 1'b0, 1'b0);  // input valid one cycle in three
    run_op(1'b1, 1, 1'b0, 1'b1, 1'b0);  // gapped input plus output stall at word 5
    run_op(1'b0, 0, 1'b1, 1'b0, 1'b0);  // start/in_valid poked while busy
    reset_mid_ldb();
    for (int r = 0; r < 4; r++) begin
      run_op(1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time bound in case a wait loop never sees the event it needs.
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
